// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared definitions for the ID/EX pipeline register.
//   - default datapath, register-address, ALU-op and counter widths
//   - ALU operation encodings
//   - decode control bundle and its bubble value (all zeros)
//   - REG_ZERO: the hard-wired zero register, never a forwarding or hazard source
package id_ex_stage_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned ALUOP_W_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 16;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluNor = 4'd5,
    AluSlt = 4'd6,
    AluSll = 4'd7,
    AluSrl = 4'd8,
    AluSra = 4'd9,
    AluLui = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// forward_mux: single-operand EX-stage forwarding selector.
//   i_src             register address the operand was read from
//   i_reg_data        value captured from the register file
//   i_exmem_*         EX/MEM write flag, destination and ALU result
//   i_memwb_*         MEM/WB write flag, destination and write-back data
//   o_operand         forwarded operand
// EX/MEM is the younger result, so it wins over MEM/WB. Register zero is never forwarded.
module forward_mux
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_src,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_exmem_reg_write,
  input  logic [ADDR_W-1:0] i_exmem_dest,
  input  logic [DATA_W-1:0] i_exmem_data,
  input  logic              i_memwb_reg_write,
  input  logic [ADDR_W-1:0] i_memwb_dest,
  input  logic [DATA_W-1:0] i_memwb_data,
  output logic [DATA_W-1:0] o_operand
);

  logic exmem_hit;
  logic memwb_hit;

  always_comb begin
    exmem_hit = i_exmem_reg_write && (i_exmem_dest != ADDR_W'(REG_ZERO)) &&
                (i_exmem_dest == i_src);
    memwb_hit = i_memwb_reg_write && (i_memwb_dest != ADDR_W'(REG_ZERO)) &&
                (i_memwb_dest == i_src);
    if (exmem_hit) begin
      o_operand = i_exmem_data;
    end else if (memwb_hit) begin
      o_operand = i_memwb_data;
    end else begin
      o_operand = i_reg_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the MIPS datapath.
//   clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_enable            debug step enable; 0 freezes all state and masks o_stall
//   i_flush             taken branch/jump; load a bubble
//   i_rs/i_rt/i_uses_rt decode source addresses (used for hazard detection and forwarding)
//   i_data_rs/rt, i_imm register-file data and sign-extended immediate
//   i_dest, control     decode destination and control bits
//   i_exmem_*, i_memwb_* later-stage results for forwarding
//   o_stall             load-use hazard: hold PC and IF/ID this cycle
//   o_op_a/o_op_b_reg   forwarded rs/rt operands
//   o_imm/o_dest/ctrl   registered decode fields
//   o_stall_count       saturating count of load-use bubbles
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic [ADDR_W-1:0]  i_rs,
  input  logic [ADDR_W-1:0]  i_rt,
  input  logic               i_uses_rt,
  input  logic [DATA_W-1:0]  i_data_rs,
  input  logic [DATA_W-1:0]  i_data_rt,
  input  logic [DATA_W-1:0]  i_imm,
  input  logic [ADDR_W-1:0]  i_dest,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_mem_to_reg,
  input  logic               i_alu_src,
  input  logic [ALUOP_W-1:0] i_alu_op,
  input  logic               i_exmem_reg_write,
  input  logic [ADDR_W-1:0]  i_exmem_dest,
  input  logic [DATA_W-1:0]  i_exmem_data,
  input  logic               i_memwb_reg_write,
  input  logic [ADDR_W-1:0]  i_memwb_dest,
  input  logic [DATA_W-1:0]  i_memwb_data,
  output logic               o_stall,
  output logic [DATA_W-1:0]  o_op_a,
  output logic [DATA_W-1:0]  o_op_b_reg,
  output logic [DATA_W-1:0]  o_imm,
  output logic [ADDR_W-1:0]  o_dest,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg,
  output logic               o_alu_src,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [CNT_W-1:0]   o_stall_count
);

  ctrl_t              ctrl_d, ctrl_q;
  logic [ADDR_W-1:0]  rs_d, rs_q, rt_d, rt_q, dest_d, dest_q;
  logic [DATA_W-1:0]  rs_data_d, rs_data_q, rt_data_d, rt_data_q, imm_d, imm_q;
  logic [ALUOP_W-1:0] alu_op_d, alu_op_q;
  logic [CNT_W-1:0]   stall_count_d, stall_count_q;
  logic               stall;

  // Load-use hazard: the load now in EX cannot forward in time to the instruction in ID.
  always_comb begin
    stall = 1'b0;
    if (i_enable && ctrl_q.mem_read && (dest_q != ADDR_W'(REG_ZERO))) begin
      stall = (dest_q == i_rs) || (i_uses_rt && (dest_q == i_rt));
    end
  end

  assign o_stall = stall;

  always_comb begin
    ctrl_d        = ctrl_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    dest_d        = dest_q;
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    imm_d         = imm_q;
    alu_op_d      = alu_op_q;
    stall_count_d = stall_count_q;
    if (i_enable) begin
      if (i_flush || stall) begin
        ctrl_d    = CTRL_BUBBLE;
        rs_d      = '0;
        rt_d      = '0;
        dest_d    = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        alu_op_d  = '0;
        // Only load-use bubbles are counted; a flush overrides a coincident stall.
        if (!i_flush && (stall_count_q != {CNT_W{1'b1}})) begin
          stall_count_d = stall_count_q + CNT_W'(1);
        end
      end else begin
        ctrl_d.reg_write  = i_reg_write;
        ctrl_d.mem_read   = i_mem_read;
        ctrl_d.mem_write  = i_mem_write;
        ctrl_d.mem_to_reg = i_mem_to_reg;
        ctrl_d.alu_src    = i_alu_src;
        rs_d              = i_rs;
        rt_d              = i_rt;
        dest_d            = i_dest;
        rs_data_d         = i_data_rs;
        rt_data_d         = i_data_rt;
        imm_d             = i_imm;
        alu_op_d          = i_alu_op;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q        <= CTRL_BUBBLE;
      rs_q          <= '0;
      rt_q          <= '0;
      dest_q        <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      alu_op_q      <= '0;
      stall_count_q <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      dest_q        <= dest_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      alu_op_q      <= alu_op_d;
      stall_count_q <= stall_count_d;
    end
  end

  forward_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fwd_rs (
    .i_src             (rs_q),
    .i_reg_data        (rs_data_q),
    .i_exmem_reg_write (i_exmem_reg_write),
    .i_exmem_dest      (i_exmem_dest),
    .i_exmem_data      (i_exmem_data),
    .i_memwb_reg_write (i_memwb_reg_write),
    .i_memwb_dest      (i_memwb_dest),
    .i_memwb_data      (i_memwb_data),
    .o_operand         (o_op_a)
  );

  forward_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fwd_rt (
    .i_src             (rt_q),
    .i_reg_data        (rt_data_q),
    .i_exmem_reg_write (i_exmem_reg_write),
    .i_exmem_dest      (i_exmem_dest),
    .i_exmem_data      (i_exmem_data),
    .i_memwb_reg_write (i_memwb_reg_write),
    .i_memwb_dest      (i_memwb_dest),
    .i_memwb_data      (i_memwb_data),
    .o_operand         (o_op_b_reg)
  );

  assign o_imm         = imm_q;
  assign o_dest        = dest_q;
  assign o_reg_write   = ctrl_q.reg_write;
  assign o_mem_read    = ctrl_q.mem_read;
  assign o_mem_write   = ctrl_q.mem_write;
  assign o_mem_to_reg  = ctrl_q.mem_to_reg;
  assign o_alu_src     = ctrl_q.alu_src;
  assign o_alu_op      = alu_op_q;
  assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage (CNT_W=4 so saturation is reachable).
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 4;
  localparam int unsigned CW = 4;

  // Control vectors: {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
  localparam logic [4:0] C_ALU = 5'b10000;
  localparam logic [4:0] C_LW  = 5'b11011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst_n, i_enable, i_flush, i_uses_rt;
  logic [AW-1:0] i_rs, i_rt, i_dest, i_exmem_dest, i_memwb_dest;
  logic [DW-1:0] i_data_rs, i_data_rt, i_imm, i_exmem_data, i_memwb_data;
  logic          i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src;
  logic [OW-1:0] i_alu_op;
  logic          i_exmem_reg_write, i_memwb_reg_write;
  logic          o_stall, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src;
  logic [DW-1:0] o_op_a, o_op_b_reg, o_imm;
  logic [AW-1:0] o_dest;
  logic [OW-1:0] o_alu_op;
  logic [CW-1:0] o_stall_count;
  logic [4:0]    o_ctrl;

  assign o_ctrl = {o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src};

  id_ex_stage #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .ALUOP_W(OW),
    .CNT_W  (CW)
  ) dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .i_enable         (i_enable),
    .i_flush          (i_flush),
    .i_rs             (i_rs),
    .i_rt             (i_rt),
    .i_uses_rt        (i_uses_rt),
    .i_data_rs        (i_data_rs),
    .i_data_rt        (i_data_rt),
    .i_imm            (i_imm),
    .i_dest           (i_dest),
    .i_reg_write      (i_reg_write),
    .i_mem_read       (i_mem_read),
    .i_mem_write      (i_mem_write),
    .i_mem_to_reg     (i_mem_to_reg),
    .i_alu_src        (i_alu_src),
    .i_alu_op         (i_alu_op),
    .i_exmem_reg_write(i_exmem_reg_write),
    .i_exmem_dest     (i_exmem_dest),
    .i_exmem_data     (i_exmem_data),
    .i_memwb_reg_write(i_memwb_reg_write),
    .i_memwb_dest     (i_memwb_dest),
    .i_memwb_data     (i_memwb_data),
    .o_stall          (o_stall),
    .o_op_a           (o_op_a),
    .o_op_b_reg       (o_op_b_reg),
    .o_imm            (o_imm),
    .o_dest           (o_dest),
    .o_reg_write      (o_reg_write),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .o_mem_to_reg     (o_mem_to_reg),
    .o_alu_src        (o_alu_src),
    .o_alu_op         (o_alu_op),
    .o_stall_count    (o_stall_count)
  );

  typedef struct {
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] imm;
    logic [AW-1:0] dest;
    logic [4:0]    ctrl;
    logic [OW-1:0] alu_op;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference state of the pipeline register
  logic [AW-1:0] m_rs, m_rt, m_dest;
  logic [DW-1:0] m_drs, m_drt, m_imm;
  logic [4:0]    m_ctrl;
  logic [OW-1:0] m_alu;
  logic [CW-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear(input bit with_count);
    m_rs = '0; m_rt = '0; m_dest = '0; m_drs = '0; m_drt = '0; m_imm = '0;
    m_ctrl = '0; m_alu = '0;
    if (with_count) m_cnt = '0;
  endtask

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] src, input logic [DW-1:0] rdata);
    if (i_exmem_reg_write && i_exmem_dest != 0 && i_exmem_dest == src) return i_exmem_data;
    if (i_memwb_reg_write && i_memwb_dest != 0 && i_memwb_dest == src) return i_memwb_data;
    return rdata;
  endfunction

  function automatic logic model_stall();
    return i_enable && m_ctrl[3] && (m_dest != 0) &&
           ((m_dest == i_rs) || (i_uses_rt && (m_dest == i_rt)));
  endfunction

  task automatic set_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic urt,
                           input logic [DW-1:0] drs, input logic [DW-1:0] drt,
                           input logic [DW-1:0] imm, input logic [AW-1:0] dest,
                           input logic [4:0] ctrl, input logic [OW-1:0] aop);
    i_rs = rs; i_rt = rt; i_uses_rt = urt; i_data_rs = drs; i_data_rt = drt; i_imm = imm;
    i_dest = dest;
    {i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src} = ctrl;
    i_alu_op = aop;
  endtask

  task automatic set_fwd(input logic ew, input logic [AW-1:0] ed, input logic [DW-1:0] edat,
                         input logic mw, input logic [AW-1:0] md, input logic [DW-1:0] mdat);
    i_exmem_reg_write = ew; i_exmem_dest = ed; i_exmem_data = edat;
    i_memwb_reg_write = mw; i_memwb_dest = md; i_memwb_data = mdat;
  endtask

  // Called just after a falling edge with inputs set: check o_stall, predict, clock, compare.
  task automatic cycle();
    logic st;
    exp_t e;
    #1;
    st = model_stall();
    check_eq("stall", {31'd0, o_stall}, {31'd0, st});
    if (i_enable) begin
      if (i_flush || st) begin
        model_clear(1'b0);
        if (!i_flush && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      end else begin
        m_rs = i_rs; m_rt = i_rt; m_dest = i_dest; m_drs = i_data_rs; m_drt = i_data_rt;
        m_imm = i_imm; m_alu = i_alu_op;
        m_ctrl = {i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src};
      end
    end
    e.op_a = fwd(m_rs, m_drs);
    e.op_b = fwd(m_rt, m_drt);
    e.imm = m_imm; e.dest = m_dest; e.ctrl = m_ctrl; e.alu_op = m_alu; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("op_a", o_op_a, e.op_a);
      check_eq("op_b_reg", o_op_b_reg, e.op_b);
      check_eq("imm", o_imm, e.imm);
      check_eq("dest", {27'd0, o_dest}, {27'd0, e.dest});
      check_eq("ctrl", {27'd0, o_ctrl}, {27'd0, e.ctrl});
      check_eq("alu_op", {28'd0, o_alu_op}, {28'd0, e.alu_op});
      check_eq("stall_count", {28'd0, o_stall_count}, {28'd0, e.cnt});
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with arbitrary activity on every input
    i_rst_n = 1'b0; i_enable = 1'b1; i_flush = 1'b0;
    set_instr(5'd8, 5'd9, 1'b1, 32'hdead, 32'hbeef, 32'h1234, 5'd8, C_LW, OW'(AluSub));
    set_fwd(1'b1, 5'd8, 32'haaaa, 1'b1, 5'd9, 32'hbbbb);
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_op_a", o_op_a, 32'd0);
    check_eq("rst_op_b", o_op_b_reg, 32'd0);
    check_eq("rst_ctrl", {27'd0, o_ctrl}, 32'd0);
    check_eq("rst_dest", {27'd0, o_dest}, 32'd0);
    check_eq("rst_stall", {31'd0, o_stall}, 32'd0);
    check_eq("rst_cnt", {28'd0, o_stall_count}, 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // add r3, r1, r2 with register data 5 and 7
    set_instr(5'd1, 5'd2, 1'b1, 32'd5, 32'd7, 32'd0, 5'd3, C_ALU, OW'(AluAdd));
    cycle();
    check_eq("add_op_a", o_op_a, 32'd5);
    check_eq("add_op_b", o_op_b_reg, 32'd7);
    check_eq("add_dest", {27'd0, o_dest}, 32'd3);
    check_eq("add_reg_write", {31'd0, o_reg_write}, 32'd1);

    // Forwarding priority on rs=r4 (register data 0x99), rt=r5 (0x55)
    set_instr(5'd4, 5'd5, 1'b1, 32'h99, 32'h55, 32'h10, 5'd6, C_ALU, OW'(AluOr));
    set_fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
    cycle();
    check_eq("fwd_exmem_prio", o_op_a, 32'h11);
    set_fwd(1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
    cycle();
    check_eq("fwd_memwb", o_op_a, 32'h22);
    set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
    cycle();
    check_eq("fwd_r0_blocked", o_op_a, 32'h99);
    set_fwd(1'b0, 5'd0, 32'h11, 1'b1, 5'd5, 32'h33);
    cycle();
    check_eq("fwd_rt_memwb", o_op_b_reg, 32'h33);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Load-use on rs
    set_instr(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 32'h4, 5'd8, C_LW, OW'(AluAdd));
    cycle();
    set_instr(5'd8, 5'd2, 1'b1, 32'h77, 32'h66, 32'h0, 5'd9, C_ALU, OW'(AluAdd));
    #1;
    check_eq("lu_stall", {31'd0, o_stall}, 32'd1);
    cycle();
    check_eq("lu_bubble_rw", {31'd0, o_reg_write}, 32'd0);
    check_eq("lu_count", {28'd0, o_stall_count}, 32'd1);
    cycle();
    check_eq("lu_one_cycle", {27'd0, o_dest}, 32'd9);

    // rt not a source, and load to r0
    set_instr(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 32'h4, 5'd8, C_LW, OW'(AluAdd));
    cycle();
    set_instr(5'd1, 5'd8, 1'b0, 32'h1, 32'h2, 32'h3, 5'd10, C_ALU, OW'(AluAnd));
    #1;
    check_eq("rt_unused_stall", {31'd0, o_stall}, 32'd0);
    cycle();
    set_instr(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 32'h4, 5'd0, C_LW, OW'(AluAdd));
    cycle();
    set_instr(5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 5'd11, C_ALU, OW'(AluAdd));
    #1;
    check_eq("lw_r0_stall", {31'd0, o_stall}, 32'd0);
    cycle();

    // Flush beats a coincident stall
    set_instr(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 32'h4, 5'd8, C_LW, OW'(AluAdd));
    cycle();
    set_instr(5'd8, 5'd2, 1'b1, 32'h77, 32'h66, 32'h0, 5'd9, C_ALU, OW'(AluAdd));
    i_flush = 1'b1;
    cycle();
    check_eq("flush_count", {28'd0, o_stall_count}, 32'd1);
    check_eq("flush_bubble_rw", {31'd0, o_reg_write}, 32'd0);
    i_flush = 1'b0;

    // Frozen while disabled, with a load-use condition pending
    set_instr(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 32'h4, 5'd8, C_LW, OW'(AluAdd));
    cycle();
    set_instr(5'd8, 5'd2, 1'b1, 32'h77, 32'h66, 32'h0, 5'd9, C_ALU, OW'(AluAdd));
    i_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("frozen_dest", {27'd0, o_dest}, 32'd8);
    end
    i_enable = 1'b1;
    cycle();
    check_eq("resume_count", {28'd0, o_stall_count}, 32'd2);

    // Reset while stalling drops o_stall at once
    set_instr(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 32'h4, 5'd8, C_LW, OW'(AluAdd));
    cycle();
    set_instr(5'd8, 5'd2, 1'b1, 32'h77, 32'h66, 32'h0, 5'd9, C_ALU, OW'(AluAdd));
    #1;
    check_eq("pre_rst_stall", {31'd0, o_stall}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_stall", {31'd0, o_stall}, 32'd0);
    check_eq("mid_rst_count", {28'd0, o_stall_count}, 32'd0);
    model_clear(1'b1);
    @(negedge clk);
    i_rst_n = 1'b1;

    // Saturation: 18 load-use bubbles into a 4-bit counter
    for (int k = 0; k < 18; k++) begin
      set_instr(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 32'h4, 5'd8, C_LW, OW'(AluAdd));
      cycle();
      set_instr(5'd2, 5'd8, 1'b1, 32'h5, 32'h6, 32'h0, 5'd12, C_ALU, OW'(AluSlt));
      cycle();
    end
    check_eq("sat_count", {28'd0, o_stall_count}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
